pwm_bank: RTL
=============

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning counter/duty/period width in bits (2..16).
REQ-002 SHALL have parameter CH, default 4, meaning number of output channels (1..16).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port en  input  1  counter advance enable.
REQ-006 SHALL have port period  input  CNT_W  terminal count; counter wraps after reaching it.
REQ-007 SHALL have port cfg_valid  input  1  configuration write request.
REQ-008 SHALL have port cfg_ready  output  1  configuration slot free.
REQ-009 SHALL have port cfg_ch  input  max(1,clog2(CH))  target channel index.
REQ-010 SHALL have port cfg_mode  input  2  channel mode: 00 off, 01 PWM, 10 toggle, 11 one-shot.
REQ-011 SHALL have port cfg_duty  input  CNT_W  PWM compare value.
REQ-012 SHALL have port out  output  CH  registered channel outputs.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse following each counter wrap.

Function
REQ-014 SHALL keep a free-running counter cnt; on each edge with en=1: if cnt>=period, cnt<=0 (wrap event), else cnt<=cnt+1.
REQ-015 SHALL use >= in wrap compare so lowering period below cnt wraps on next enabled edge; period=0 wraps every enabled edge.
REQ-016 SHALL assert wrap for exactly the cycle after each wrap event; wrap=0 otherwise.
REQ-017 SHALL, with en=0, hold cnt, hold all out bits, keep wrap=0, not commit pending config.
REQ-018 SHALL hold per-channel active mode/duty registers; outputs use active values only.
REQ-019 SHALL provide one pending config slot (ch, mode, duty); transfer occurs on edge with cfg_valid=1 and cfg_ready=1.
REQ-020 SHALL drive cfg_ready=0 while the slot is pending; cfg_ready=1 otherwise.
REQ-021 SHALL commit pending slot to the active registers of its channel on the wrap event edge and clear pending (cfg_ready=1 next cycle).
REQ-022 SHALL, when a transfer and a wrap event coincide, commit the previously pending slot (if any); with no prior pending, the new write stays pending until the following wrap.
REQ-023 SHALL accept and discard writes with cfg_ch>=CH (slot still occupied until next wrap; no channel changes).
REQ-024 SHALL compute on enabled edges: PWM out[i]<=(cnt<duty_i); duty 0 gives constant 0, duty>period gives constant 1.
REQ-025 SHALL in toggle mode invert out[i] on each wrap event edge, hold otherwise.
REQ-026 SHALL in one-shot mode set out[i]=1 on the wrap event edge and 0 on all other edges.
REQ-027 SHALL in off mode drive out[i]=0 on next enabled edge; mode change via commit takes effect from the commit edge's next computation.
REQ-028 SHALL compute out[i] with one cycle latency from cnt value (registered, glitch-free).

Reset
REQ-029 SHALL on rst=1 at an edge set cnt=0, out=0, wrap=0, all modes off, all duties 0, pending cleared; rst overrides en and cfg_valid.
REQ-030 SHALL drive cfg_ready=0 during reset cycles and 1 on the first cycle after rst deasserts.
REQ-031 SHALL discard a pending slot when reset arrives mid-period; no commit occurs.

Verification
REQ-032 SHALL cover: CNT_W=8, period=9, ch0 PWM duty=3, en=1 -> out[0] high 3 of every 10 cycles, wrap every 10 cycles.
REQ-033 SHALL cover: write ch1 duty=7 mid-period -> cfg_ready=0 until wrap; old duty persists to wrap; new duty from next period.
REQ-034 SHALL cover: ch2 toggle, period=4 -> out[2] period 10 cycles; ch3 one-shot -> 1-cycle pulse aligned with wrap.
REQ-035 SHALL cover: duty=0 -> out stuck 0; duty=255, period=9 -> out stuck 1; period=0 -> wrap constant 1.
REQ-036 SHALL cover: en=0 for 5 cycles mid-period -> cnt, out frozen, no wrap; resume exact phase.
REQ-037 SHALL cover: rst with pending write and cnt=6 -> next cycle cnt=0, out=0, channel unchanged from reset values, cfg_ready=1 after release.

Source files
------------

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: one shared period counter, per-channel PWM/toggle/one-shot
// outputs, and a single-slot configuration buffer that commits on counter wrap.
module pwm_bank #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned CH    = 4,
  localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic [CH-1:0]    out,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_OFF = 2'b00,
    MODE_PWM = 2'b01,
    MODE_TOG = 2'b10,
    MODE_ONE = 2'b11
  } mode_e;

  logic [CNT_W-1:0] cnt_q;
  mode_e            mode_q [CH];
  logic [CNT_W-1:0] duty_q [CH];

  logic             pend_q;
  logic [CH_W-1:0]  pend_ch_q;
  mode_e            pend_mode_q;
  logic [CNT_W-1:0] pend_duty_q;

  logic             wrap_evt_c;
  logic             xfer_c;
  logic             pend_nxt_c;
  logic [CH-1:0]    out_nxt_c;

  // Wrap detection, handshake and next output values from the active registers.
  always_comb begin
    wrap_evt_c = en && (cnt_q >= period);
    xfer_c     = cfg_valid && cfg_ready;
    pend_nxt_c = pend_q;
    out_nxt_c  = out;
    if (xfer_c) begin
      pend_nxt_c = 1'b1;
    end else if (wrap_evt_c) begin
      pend_nxt_c = 1'b0;
    end
    if (en) begin
      for (int i = 0; i < int'(CH); i++) begin
        case (mode_q[i])
          MODE_PWM: out_nxt_c[i] = (cnt_q < duty_q[i]);
          MODE_TOG: out_nxt_c[i] = wrap_evt_c ? ~out[i] : out[i];
          MODE_ONE: out_nxt_c[i] = wrap_evt_c;
          default:  out_nxt_c[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      out         <= '0;
      wrap        <= 1'b0;
      cfg_ready   <= 1'b0;
      pend_q      <= 1'b0;
      pend_ch_q   <= '0;
      pend_mode_q <= MODE_OFF;
      pend_duty_q <= '0;
      for (int i = 0; i < int'(CH); i++) begin
        mode_q[i] <= MODE_OFF;
        duty_q[i] <= '0;
      end
    end else begin
      wrap      <= wrap_evt_c;
      out       <= out_nxt_c;
      cfg_ready <= ~pend_nxt_c;
      pend_q    <= pend_nxt_c;
      if (en) begin
        cnt_q <= wrap_evt_c ? '0 : cnt_q + CNT_W'(1);
      end
      // Out-of-range channel indices match no channel and are dropped here.
      if (wrap_evt_c && pend_q) begin
        for (int i = 0; i < int'(CH); i++) begin
          if (pend_ch_q == CH_W'(i)) begin
            mode_q[i] <= pend_mode_q;
            duty_q[i] <= pend_duty_q;
          end
        end
      end
      if (xfer_c) begin
        pend_ch_q   <= cfg_ch;
        pend_mode_q <= mode_e'(cfg_mode);
        pend_duty_q <= cfg_duty;
      end
    end
  end

endmodule
